// File: rtl/cache_pkg.sv
// Shared types, widths and address field positions for the 2-way cache controller.
package cache_pkg;
  localparam int LINE_W    = 128;
  localparam int TAG_W     = 27;
  localparam int IDX_W_DEF = 6;
  localparam int ADDR_W    = 31;
  localparam int WORD_W    = 32;
  localparam int CNT_W     = 16;
  localparam int LINE_LSB  = 4;
  localparam int IDX_LSB   = 4;
  localparam int WS_LSB    = 2;
  localparam int WS_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } state_t;

  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [WS_W-1:0]   ws);
    return line[WORD_W*ws +: WORD_W];
  endfunction
endpackage

// File: rtl/cache_repl.sv
// Per-set valid bits and LRU state for a 2-way cache, plus victim selection.
module cache_repl
  import cache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_hit,
  input  logic             i_hit_way,
  input  logic             i_fill,
  input  logic             i_fill_way,
  output logic             o_valid0,
  output logic             o_valid1,
  output logic             o_victim,
  output logic             o_victim_valid
);
  localparam int SETS = 1 << IDX_W;

  // r_lru holds the way to evict next when both ways are valid
  logic [SETS-1:0] r_valid0;
  logic [SETS-1:0] r_valid1;
  logic [SETS-1:0] r_lru;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else if (i_fill) begin
      if (i_fill_way) r_valid1[i_idx] <= 1'b1;
      else            r_valid0[i_idx] <= 1'b1;
      r_lru[i_idx] <= ~i_fill_way;
    end else if (i_hit) begin
      r_lru[i_idx] <= ~i_hit_way;
    end
  end

  assign o_valid0       = r_valid0[i_idx];
  assign o_valid1       = r_valid1[i_idx];
  assign o_victim_valid = o_valid0 & o_valid1;

  always_comb begin
    o_victim = 1'b0;
    if (!o_valid0)      o_victim = 1'b0;
    else if (!o_valid1) o_victim = 1'b1;
    else                o_victim = r_lru[i_idx];
  end
endmodule

// File: rtl/cache_ctrl.sv
// 2-way set-associative read cache controller with line refill; the external array is combinational.
// Optional hit/miss statistics counters are built when CACHE_CTRL_STAT_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for cpu_req, captures address on acceptance
// ST_LOOKUP | array read of the set, hit returns data here
// ST_REFILL | mem_req held until mem_ack, line captured
// ST_WRITE  | one-cycle array write of the refilled line into the victim way
// ST_RESP   | return requested word from the captured line
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              valid_r_o,
  output logic [IDX_W-1:0]  r_addr_o,
  output logic [IDX_W:0]    w_addr_o,
  output logic [TAG_W-1:0]  data_addr_o,
  output logic [LINE_W-1:0] data_d_o,
  output logic              valid_w_o,
  output logic              chg_o,
  input  logic [LINE_W-1:0] data_i1,
  input  logic [LINE_W-1:0] data_i2,
  input  logic [TAG_W-1:0]  addr_i1,
  input  logic [TAG_W-1:0]  addr_i2,
  output logic              mem_req,
  output logic [TAG_W-1:0]  mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  state_t            r_state;
  state_t            w_next;
  logic [TAG_W-1:0]  r_line;
  logic [WS_W-1:0]   r_ws;
  logic [LINE_W-1:0] r_data;
  logic              r_victim;
  logic              r_victim_valid;
  logic [IDX_W-1:0]  w_idx;
  logic              w_valid0;
  logic              w_valid1;
  logic              w_victim;
  logic              w_victim_valid;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_hit;
  logic              w_lookup;
  logic              w_unused;

  assign w_idx    = r_line[IDX_LSB-LINE_LSB +: IDX_W];
  assign w_hit0   = w_valid0 && (addr_i1 == r_line);
  assign w_hit1   = w_valid1 && (addr_i2 == r_line);
  assign w_hit    = w_hit0 | w_hit1;
  assign w_lookup = (r_state == ST_LOOKUP);
  assign w_unused = ^cpu_addr[WS_LSB-1:0];

  cache_repl #(.IDX_W(IDX_W)) u_repl (
    .clk            (clk),
    .i_rst_n        (rst),
    .i_idx          (w_idx),
    .i_hit          (w_lookup && w_hit),
    .i_hit_way      (~w_hit0),
    .i_fill         (r_state == ST_WRITE),
    .i_fill_way     (r_victim),
    .o_valid0       (w_valid0),
    .o_valid1       (w_valid1),
    .o_victim       (w_victim),
    .o_victim_valid (w_victim_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (cpu_req) w_next = ST_LOOKUP;
      ST_LOOKUP: w_next = w_hit ? ST_IDLE : ST_REFILL;
      ST_REFILL: if (mem_ack) w_next = ST_WRITE;
      ST_WRITE:  w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    valid_r_o   = 1'b0;
    r_addr_o    = '0;
    valid_w_o   = 1'b0;
    w_addr_o    = '0;
    data_addr_o = '0;
    data_d_o    = '0;
    chg_o       = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    unique case (r_state)
      ST_LOOKUP: begin
        valid_r_o = 1'b1;
        r_addr_o  = w_idx;
        if (w_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = word_sel(w_hit0 ? data_i1 : data_i2, r_ws);
        end
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = r_line;
      end
      ST_WRITE: begin
        valid_w_o   = 1'b1;
        w_addr_o    = {r_victim, w_idx};
        data_addr_o = r_line;
        data_d_o    = r_data;
        chg_o       = r_victim_valid;
      end
      ST_RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = word_sel(r_data, r_ws);
      end
      default: ;
    endcase
  end

  // victim is frozen at the LOOKUP->REFILL step so the later WRITE cannot see a changed set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line         <= '0;
      r_ws           <= '0;
      r_data         <= '0;
      r_victim       <= 1'b0;
      r_victim_valid <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && cpu_req) begin
        r_line <= cpu_addr[LINE_LSB +: TAG_W];
        r_ws   <= cpu_addr[WS_LSB +: WS_W];
      end
      if (w_lookup && !w_hit) begin
        r_victim       <= w_victim;
        r_victim_valid <= w_victim_valid;
      end
      if (r_state == ST_REFILL && mem_ack) r_data <= mem_rdata;
    end
  end

`ifdef CACHE_CTRL_STAT_EN
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_lookup) begin
      if (w_hit && r_hit_cnt != '1)    r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (!w_hit && r_miss_cnt != '1)  r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: emulates the tag/data array and memory, predicts
// behaviour from a timestamp-LRU residency model. Counter expectations follow CACHE_CTRL_STAT_EN.
module tb_cache_ctrl;
`ifdef CACHE_CTRL_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [30:0]  cpu_addr;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         valid_r_o;
  logic [5:0]   r_addr_o;
  logic [6:0]   w_addr_o;
  logic [26:0]  data_addr_o;
  logic [127:0] data_d_o;
  logic         valid_w_o;
  logic         chg_o;
  logic [127:0] data_i1, data_i2;
  logic [26:0]  addr_i1, addr_i2;
  logic         mem_req;
  logic [26:0]  mem_addr;
  logic         mem_ack;
  logic [127:0] mem_rdata;
  logic [15:0]  hit_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;

  cache_ctrl #(.IDX_W(6)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .valid_r_o(valid_r_o),
    .r_addr_o(r_addr_o), .w_addr_o(w_addr_o), .data_addr_o(data_addr_o),
    .data_d_o(data_d_o), .valid_w_o(valid_w_o), .chg_o(chg_o),
    .data_i1(data_i1), .data_i2(data_i2), .addr_i1(addr_i1), .addr_i2(addr_i2),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // external array: not cleared by reset, written only through the DUT write port
  logic [26:0]  arr_tag [2][64] = '{default: '0};
  logic [127:0] arr_dat [2][64] = '{default: '0};
  assign addr_i1 = arr_tag[0][r_addr_o];
  assign addr_i2 = arr_tag[1][r_addr_o];
  assign data_i1 = arr_dat[0][r_addr_o];
  assign data_i2 = arr_dat[1][r_addr_o];
  always @(posedge clk) begin
    if (valid_w_o) begin
      arr_tag[w_addr_o[6]][w_addr_o[5:0]] <= data_addr_o;
      arr_dat[w_addr_o[6]][w_addr_o[5:0]] <= data_d_o;
    end
  end

  // reference model: which line sits in which way, and when each way was last used
  bit          m_valid [2][64];
  logic [26:0] m_line  [2][64];
  int          m_stamp [2][64];
  int          m_time, m_hits, m_misses;

  bit          o_hit, o_chg;
  logic [31:0] o_rdata;
  logic [6:0]  o_waddr;
  logic [26:0] o_maddr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [26:0] l);
    logic [31:0] h;
    if (l == 27'h1) return {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
    h = {5'b0, l} * 32'h9E3779B1;
    return {h ^ 32'hF00F0003, h ^ 32'h0FF00002, h ^ 32'h33330001, h};
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 64; s++) begin
        m_valid[w][s] = 1'b0;
        m_stamp[w][s] = 0;
        m_line[w][s]  = '0;
      end
    m_time = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic apply_reset();
    cpu_req = 1'b0; mem_ack = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"},  hit_cnt,  STAT ? sat(m_hits)   : 0);
    check({tag, "_miss_cnt"}, miss_cnt, STAT ? sat(m_misses) : 0);
  endtask

  // entered and left on a falling edge with the DUT idle
  task automatic do_read(input logic [30:0] addr, input int dly);
    logic [26:0]  l;
    logic [5:0]   idx;
    logic [1:0]   ws;
    logic [127:0] line;
    logic [31:0]  expw;
    bit           hit, evict;
    int           hw, vic;
    l = addr[30:4]; idx = l[5:0]; ws = addr[3:2];
    line = mem_line(l);
    expw = line[32*ws +: 32];
    hit = 1'b0; hw = 0;
    for (int w = 1; w >= 0; w--)
      if (m_valid[w][idx] && m_line[w][idx] == l) begin hit = 1'b1; hw = w; end
    cpu_req = 1'b1; cpu_addr = addr;
    @(posedge clk);
    @(negedge clk);
    check("lookup_valid_r", valid_r_o, 1);
    check("lookup_r_addr", r_addr_o, idx);
    check("lookup_ready", cpu_ready, hit);
    o_hit = cpu_ready;
    if (hit) begin
      check("hit_rdata", cpu_rdata, expw);
      check("hit_mem_req", mem_req, 0);
      o_rdata = cpu_rdata;
      cpu_req = 1'b0;
      m_time++; m_stamp[hw][idx] = m_time; m_hits++;
    end else begin
      m_misses++;
      if (!m_valid[0][idx])      vic = 0;
      else if (!m_valid[1][idx]) vic = 1;
      else                       vic = (m_stamp[0][idx] < m_stamp[1][idx]) ? 0 : 1;
      evict = m_valid[0][idx] && m_valid[1][idx];
      for (int c = 0; c <= dly; c++) begin
        @(negedge clk);
        check("refill_mem_req", mem_req, 1);
        check("refill_mem_addr", mem_addr, l);
        check("refill_ready", cpu_ready, 0);
        if (c == 0) o_maddr = mem_addr;
        mem_ack   = (c == dly);
        mem_rdata = (c == dly) ? line : {4{$urandom}};
      end
      @(negedge clk);
      mem_ack = 1'b0;
      check("write_valid_w", valid_w_o, 1);
      check("write_w_addr", w_addr_o, {vic[0], idx});
      check("write_data_addr", data_addr_o, l);
      check("write_data_d", data_d_o, line);
      check("write_chg", chg_o, evict);
      check("write_mem_req", mem_req, 0);
      o_waddr = w_addr_o; o_chg = chg_o;
      @(negedge clk);
      check("resp_ready", cpu_ready, 1);
      check("resp_rdata", cpu_rdata, expw);
      check("resp_valid_w", valid_w_o, 0);
      o_rdata = cpu_rdata;
      cpu_req = 1'b0;
      m_valid[vic][idx] = 1'b1; m_line[vic][idx] = l;
      m_time++; m_stamp[vic][idx] = m_time;
    end
    @(negedge clk);
    check("idle_ready", cpu_ready, 0);
    check_counters("txn");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = {4{$urandom}};
      @(negedge clk);
      check("idle_valid_w", valid_w_o, 0);
      check("idle_mem_req", mem_req, 0);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [30:0] a;
    cpu_req = 1'b0; cpu_addr = '0; mem_ack = 1'b0; mem_rdata = '0; rst = 1'b0;
    model_reset();
    #1;
    check("rst_ready", cpu_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_valid_r", valid_r_o, 0);
    check("rst_valid_w", valid_w_o, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // cold miss, then hit in the same line
    do_read(31'h10, 3);
    check("cold_hit", o_hit, 0);
    check("cold_mem_addr", o_maddr, 27'h1);
    check("cold_waddr", o_waddr, 7'h01);
    check("cold_chg", o_chg, 0);
    check("cold_rdata", o_rdata, 32'h0000AAAA);
    do_read(31'h18, 0);
    check("hit_flag", o_hit, 1);
    check("hit_word", o_rdata, 32'h0000CCCC);

    // second way fill, touch way0, then evict way1
    do_read(31'h410, 1);
    check("fill1_waddr", o_waddr, 7'h41);
    check("fill1_chg", o_chg, 0);
    do_read(31'h10, 0);
    check("touch_hit", o_hit, 1);
    do_read(31'h810, 2);
    check("evict_waddr", o_waddr, 7'h41);
    check("evict_chg", o_chg, 1);

    // ack in the first refill cycle
    do_read(31'h20, 0);
    check("imm_hit", o_hit, 0);
    check("imm_waddr", o_waddr, 7'h02);

    // reset while refilling
    cpu_req = 1'b1; cpu_addr = 31'h2450;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_pre_mem_req", mem_req, 1);
    rst = 1'b0;
    #1;
    check("rstmid_mem_req", mem_req, 0);
    check("rstmid_valid_w", valid_w_o, 0);
    check("rstmid_ready", cpu_ready, 0);
    check("rstmid_hit_cnt", hit_cnt, 0);
    check("rstmid_miss_cnt", miss_cnt, 0);
    cpu_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_read(31'h2450, 1);
    check("rstmid_after_hit", o_hit, 0);
    do_read(31'h10, 0);
    check("rstmid_old_line_hit", o_hit, 0);

    // 3 misses then 5 hits
    apply_reset();
    do_read(31'h100, 0);
    do_read(31'h200, 1);
    do_read(31'h300, 2);
    do_read(31'h104, 0);
    do_read(31'h108, 0);
    do_read(31'h200, 0);
    do_read(31'h30C, 0);
    do_read(31'h100, 0);
    check("cnt_hits", hit_cnt, STAT ? 5 : 0);
    check("cnt_misses", miss_cnt, STAT ? 3 : 0);

    // randomized traffic over a few sets with conflicting tags
    for (int t = 0; t < 300; t++) begin
      a = 31'(($urandom_range(0, 1) << 30) | ($urandom_range(0, 7) << 10) |
              ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      do_read(a, $urandom_range(0, 4));
      idle($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
